fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the program counter and instruction-memory fetch for the RV32I core.
//  Owns the PC register and issues one valid/ready fetch request at a time.
//  Presents each fetched instruction with its PC, and applies branch/jump redirects and trap entry.
//  Sits between the core's execute stage and the instruction memory port.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC loaded on reset
//  TRAP_VEC   32'h0000_0100  PC loaded on trap_valid (and on misalign, if enabled)
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-high
//  halt           in   1   level; blocks issue of new fetch requests
//  imem_req_valid out  1   fetch request valid
//  imem_req_addr  out  32  fetch address (word aligned)
//  imem_req_ready in   1   memory accepts request
//  imem_rsp_valid in   1   response valid (exactly one per accepted request)
//  imem_rsp_data  in   32  fetched instruction word
//  instr_valid    out  1   instruction available to core
//  instr          out  32  instruction word
//  instr_pc       out  32  PC of instr
//  instr_ready    in   1   core consumes instr (retire)
//  redirect_valid in   1   branch/jump taken, one-cycle pulse
//  redirect_pc    in   32  redirect target
//  trap_valid     in   1   trap entry, one-cycle pulse
//  fetch_misalign out  1   one-cycle pulse: misaligned redirect target (macro only)
//  retired_cnt    out  32  count of consumed instructions, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: pc=RESET_VEC, state=IDLE; all valids, instr, instr_pc, retired_cnt, fetch_misalign = 0.
//  FSM states:
//   IDLE: ->REQ next cycle if !halt.
//   REQ: imem_req_valid=1, imem_req_addr=pc; on ready ->WAIT.
//   WAIT: on rsp_valid latch instr/instr_pc=pc, ->HOLD.
//   HOLD: instr_valid=1; on instr_ready pc+=4, retired_cnt++, ->REQ (or IDLE if halt).
//   DRAIN: await outstanding response, discard it, ->REQ.
//  Request stays stable (valid, addr) until ready; halt never drops an asserted request.
//  Minimum latency: req accept at cycle N, rsp at N+1 -> instr_valid at N+2.
//  Redirect priority: trap_valid > redirect_valid > sequential pc+4.
//  Redirect/trap in any state: pc <= target next cycle; instr_valid drops next cycle.
//   From WAIT with no rsp_valid same cycle -> DRAIN; from REQ not yet accepted -> REQ with new addr.
//   From REQ with ready same cycle -> DRAIN (request already in flight).
//   From HOLD with instr_ready same cycle: instruction counts as retired; pc=target, not pc+4.
//  pc+4 wraps 32'hFFFF_FFFC -> 0; no overflow flag.
//  Without macro, redirect_pc[1:0] forced to 2'b00.
//  reset mid-operation: outstanding response after reset deassert is not expected (memory also reset).
// CONFIGURATION
//  FETCH_SEQ_MISALIGN_CHECK_EN defined:
//   redirect_pc[1:0]!=0 (no trap same cycle) -> pc=TRAP_VEC, fetch_misalign pulses 1 cycle.
//  Undefined: fetch_misalign tied 0, low bits masked as above.
// STRUCTURE
//  Shared package fetch_pkg: state enum typedef (IDLE,REQ,WAIT,HOLD,DRAIN), INSTR_W=32, PC_STEP=4.
//  One sub-module: fetch_pc_reg (async-reset PC register with load-enable and next-pc mux).
//  Remainder (FSM, skid of instr/instr_pc, retired counter) flat in fetch_sequencer.
// TESTING
//  Reset -> first imem_req_addr=0x0000_0000; ready=1, rsp next cycle -> instr_valid 2 cycles after accept.
//  Three consumed instrs, zero-wait memory -> addrs 0x0,0x4,0x8; retired_cnt=3.
//  redirect_valid, redirect_pc=0x40 while in WAIT -> old rsp discarded, next req addr 0x40, no instr_valid for old rsp.
//  trap_valid and redirect_valid same cycle (redirect_pc=0x80) -> next req addr TRAP_VEC=0x100.
//  halt=1 in HOLD with instr_ready -> IDLE, no req; halt=0 -> req at pc+4.
//  Macro on: redirect_pc=0x42 -> fetch_misalign pulse, next req 0x100; macro off -> next req 0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the fetch sequencer slice.
//   fetch_state_t : sequencer FSM states
//   pc_sel_t      : next-PC source select for fetch_pc_reg
//   INSTR_W       : instruction / PC width
//   PC_STEP       : sequential PC increment
//   align_word()  : clears the two byte-offset bits of an address
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEL_SEQ,
    PC_SEL_REDIR,
    PC_SEL_TRAP
  } pc_sel_t;

  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if -- instruction-memory request/response channel plus the
// instruction hand-off channel to the core.
//   imem_req_valid/addr/ready : fetch request (sequencer -> memory)
//   imem_rsp_valid/data       : fetch response (memory -> sequencer)
//   instr_valid/instr/pc      : fetched instruction (sequencer -> core)
//   instr_ready               : core consumes instruction
// Modports: master = sequencer side, slave = memory + core side.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic [INSTR_W-1:0] imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg -- program counter register with load enable and next-PC mux.
//   clk, reset     : clock, asynchronous active-high reset (loads RESET_VEC)
//   i_load_en      : update PC this cycle
//   i_sel          : next-PC source (sequential, redirect, trap)
//   i_redirect_pc  : redirect target; byte-offset bits are always cleared
//   o_pc           : current PC
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load_en,
  input  pc_sel_t            i_sel,
  input  logic [INSTR_W-1:0] i_redirect_pc,
  output logic [INSTR_W-1:0] o_pc
);

  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc + PC_STEP;  // wraps 0xFFFF_FFFC -> 0
    case (i_sel)
      PC_SEL_REDIR: w_pc_next = align_word(i_redirect_pc);
      PC_SEL_TRAP:  w_pc_next = TRAP_VEC;
      default:      w_pc_next = r_pc + PC_STEP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VEC;
    end else if (i_load_en) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- PC and instruction-fetch sequencer for the RV32I core.
// Issues one fetch request at a time, holds the returned instruction for the
// core, and applies trap / redirect / sequential PC updates.
//   clk, reset        : clock, asynchronous active-high reset
//   bus (master)      : imem request/response and instruction hand-off
//   i_halt            : level, blocks issue of new requests
//   i_redirect_valid  : taken branch/jump pulse, target on i_redirect_pc
//   i_trap_valid      : trap entry pulse, target TRAP_VEC (wins over redirect)
//   o_fetch_misalign  : pulse on misaligned redirect target
//   o_retired_cnt     : count of consumed instructions (wraps)
// Build option: FETCH_SEQ_MISALIGN_CHECK_EN -- when defined, a redirect target
// with nonzero low bits traps to TRAP_VEC and pulses o_fetch_misalign;
// otherwise the low bits are dropped and o_fetch_misalign stays 0.
//
// state | meaning
// IDLE  | no request; waits for halt to clear
// REQ   | request presented, waiting for imem_req_ready
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction presented to the core until instr_ready
// DRAIN | discarding the response of a request made stale by a redirect
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus,
  input  logic               i_halt,
  input  logic               i_redirect_valid,
  input  logic [INSTR_W-1:0] i_redirect_pc,
  input  logic               i_trap_valid,
  output logic               o_fetch_misalign,
  output logic [31:0]        o_retired_cnt
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [INSTR_W-1:0] w_pc;
  logic               w_pc_load;
  pc_sel_t            w_pc_sel;
  logic               w_flush;
  logic               w_misalign;
  logic               w_latch;
  logic               w_retire;
  fetch_state_t       w_issue_state;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_instr_pc;
  logic [31:0]        r_retired_cnt;

`ifdef FETCH_SEQ_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = i_redirect_valid && !i_trap_valid && (i_redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
    end
  end

  assign o_fetch_misalign = r_misalign;
`else
  assign w_misalign       = 1'b0;
  assign o_fetch_misalign = 1'b0;
`endif

  assign w_flush       = i_trap_valid || i_redirect_valid;
  // Wherever the sequencer would go on to issue, halt parks it in IDLE instead.
  assign w_issue_state = i_halt ? IDLE : REQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_sel     = PC_SEL_SEQ;
    w_latch      = 1'b0;
    w_retire     = 1'b0;

    if (w_flush) begin
      w_pc_load = 1'b1;
      w_pc_sel  = (i_trap_valid || w_misalign) ? PC_SEL_TRAP : PC_SEL_REDIR;
    end

    case (r_state)
      IDLE: begin
        if (!i_halt) w_state_next = REQ;
      end
      REQ: begin
        // An accepted request is in flight; a redirect now must drain it.
        if (bus.imem_req_ready) w_state_next = w_flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (w_flush) begin
            w_state_next = w_issue_state;
          end else begin
            w_latch      = 1'b1;
            w_state_next = HOLD;
          end
        end else if (w_flush) begin
          w_state_next = DRAIN;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          w_retire     = 1'b1;
          w_state_next = w_issue_state;
          if (!w_flush) begin
            w_pc_load = 1'b1;
            w_pc_sel  = PC_SEL_SEQ;
          end
        end else if (w_flush) begin
          w_state_next = w_issue_state;
        end
      end
      DRAIN: begin
        if (bus.imem_rsp_valid) w_state_next = w_issue_state;
      end
      default: w_state_next = IDLE;
    endcase
  end

  fetch_pc_reg #(
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .i_load_en     (w_pc_load),
    .i_sel         (w_pc_sel),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_latch) begin
      r_instr    <= bus.imem_rsp_data;
      r_instr_pc <= w_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign bus.imem_req_valid = (r_state == REQ);
  assign bus.imem_req_addr  = w_pc;
  assign bus.instr_valid    = (r_state == HOLD);
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign o_retired_cnt      = r_retired_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- directed self-checking bench for fetch_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too (all DUT outputs are registered state).
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        fetch_misalign;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus.master),
    .i_halt           (halt),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_trap_valid     (trap_valid),
    .o_fetch_misalign (fetch_misalign),
    .o_retired_cnt    (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in REQ at exp_addr; accept, respond next cycle, consume.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    chk({tag, " req_valid"}, {31'd0, bus.imem_req_valid}, 32'd1);
    chk({tag, " req_addr"}, bus.imem_req_addr, exp_addr);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    chk({tag, " wait instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk({tag, " instr_valid"}, {31'd0, bus.instr_valid}, 32'd1);
    chk({tag, " instr"}, bus.instr, data);
    chk({tag, " instr_pc"}, bus.instr_pc, exp_addr);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    halt               = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    trap_valid         = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    step();
    step();
    chk("rst req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst instr", bus.instr, 32'd0);
    chk("rst instr_pc", bus.instr_pc, 32'd0);
    chk("rst retired", retired_cnt, 32'd0);
    chk("rst misalign", {31'd0, fetch_misalign}, 32'd0);
    reset = 1'b0;
    step();

    // Sequential fetch, zero-wait memory.
    do_fetch("seq0", 32'h0, 32'h1111_1111);
    do_fetch("seq1", 32'h4, 32'h2222_2222);
    do_fetch("seq2", 32'h8, 32'h3333_3333);
    chk("seq retired", retired_cnt, 32'd3);

    // Redirect while waiting for a response: old response discarded.
    chk("rw req_addr", bus.imem_req_addr, 32'hC);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rw drain req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("rw no instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    do_fetch("rw new", 32'h40, 32'h4444_4444);
    chk("rw retired", retired_cnt, 32'd4);

    // Trap wins over a simultaneous redirect (request not yet accepted).
    trap_valid     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    do_fetch("trap", 32'h100, 32'h5555_5555);

    // Halt while consuming: park in IDLE, resume at pc+4.
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h6666_6666;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("halt instr_pc", bus.instr_pc, 32'h104);
    halt            = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("halt retired", retired_cnt, 32'd6);
    step();
    step();
    chk("halt no req", {31'd0, bus.imem_req_valid}, 32'd0);
    halt = 1'b0;
    step();
    chk("resume req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("resume req_addr", bus.imem_req_addr, 32'h108);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_SEQ_MISALIGN_CHECK_EN
    chk("misalign pulse", {31'd0, fetch_misalign}, 32'd1);
    chk("misalign addr", bus.imem_req_addr, 32'h100);
    step();
    chk("misalign pulse end", {31'd0, fetch_misalign}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
`else
    chk("masked misalign", {31'd0, fetch_misalign}, 32'd0);
    chk("masked addr", bus.imem_req_addr, 32'h40);
`endif

    // Redirect in HOLD together with instr_ready: retires, pc = target.
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h7777_7777;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("hold instr_pc", bus.instr_pc, 32'h40);
    bus.instr_ready = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h200;
    step();
    bus.instr_ready = 1'b0;
    redirect_valid  = 1'b0;
    chk("hold redir retired", retired_cnt, 32'd7);
    chk("hold redir instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("hold redir addr", bus.imem_req_addr, 32'h200);

    // Redirect in REQ with ready same cycle: drain the in-flight request.
    bus.imem_req_ready = 1'b1;
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h300;
    step();
    bus.imem_req_ready = 1'b0;
    redirect_valid     = 1'b0;
    chk("reqrdy drain req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("reqrdy no instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("reqrdy addr", bus.imem_req_addr, 32'h300);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    do_fetch("wrap", 32'hFFFF_FFFC, 32'h8888_8888);
    chk("wrap addr", bus.imem_req_addr, 32'h0);
    chk("wrap retired", retired_cnt, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
